// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit -- consumer-side hazard control for the ID/EX register
// of the 5-stage LEGv8 core.
//
// Purpose:
//   * EX-stage forwarding selects (combinational, EX/MEM beats MEM/WB,
//     XZR never forwards).
//   * Load-use stall: hold PC and IF/ID for one cycle and bubble ID/EX.
//   * Branch flush: IF/ID, ID/EX and EX/MEM flushed for FLUSH_CYCLES
//     cycles, counting the cycle in which branch_taken is seen.
//   * Memory wait: freeze the whole pipeline while mem_busy is high.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   ifid_rs1/rs2        source registers of the IF/ID instruction
//   ifid_uses_rs2       IF/ID instruction reads rs2
//   idex_rs1/rs2/rd     ID/EX register numbers
//   idex_memread        ID/EX instruction is a load
//   exmem_rd/regwrite   EX/MEM write-back fields
//   memwb_rd/regwrite   MEM/WB write-back fields
//   branch_taken        MEM-stage taken branch (one-cycle pulse)
//   mem_busy            data memory wait request
//   pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold
//                       pipeline control outputs
//   fwd_a, fwd_b        operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//
// Optional build macro HAZARD_STATS_EN adds saturating event counters
// stall_count, flush_count and hold_count (cleared by RESET).

module hazard_ctrl_unit #(
    parameter int REG_W        = 5,
    parameter int ZERO_REG     = 31,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic [REG_W-1:0] idex_rs1,
    input  logic [REG_W-1:0] idex_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      flush_count,
    output logic [31:0]      hold_count
`endif
);

    localparam logic [REG_W-1:0] ZERO_R     = REG_W'(ZERO_REG);
    // Flush cycles still owed after the cycle that sees branch_taken.
    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_FLUSH,
        ST_HOLD
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;

    // ------------------------------------------------------------------
    // Forwarding, one identical selector per ALU operand.
    // ------------------------------------------------------------------
    logic [REG_W-1:0] fwd_src [2];
    logic [1:0]       fwd_sel [2];

    assign fwd_src[0] = idex_rs1;
    assign fwd_src[1] = idex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                RESET ? 2'b00 :
                (exmem_regwrite && (exmem_rd != ZERO_R) && (exmem_rd == fwd_src[gi])) ? 2'b10 :
                (memwb_regwrite && (memwb_rd != ZERO_R) && (memwb_rd == fwd_src[gi])) ? 2'b01 :
                2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    // Load in EX whose result the IF/ID instruction needs next cycle.
    logic luh;
    assign luh = idex_memread && (idex_rd != ZERO_R) &&
                 ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_STALL: begin
                if (branch_taken) begin
                    {ifid_flush, idex_bubble, exmem_flush} = 3'b111;
                    // A one-cycle flush is complete in this cycle.
                    state_next = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_IDLE;
                    cnt_next   = FLUSH_LOAD;
                end else if (state_reg == ST_STALL) begin
                    // The bubble already removed the load, so luh is not
                    // looked at again here.
                    state_next = ST_IDLE;
                end else if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    state_next = ST_HOLD;
                end else if (luh) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = ST_STALL;
                end
            end
            ST_FLUSH: begin
                {ifid_flush, idex_bubble, exmem_flush} = 3'b111;
                // cnt_reg counts flush cycles remaining including this one.
                if (branch_taken) begin
                    cnt_next = FLUSH_LOAD;
                end else if (cnt_reg <= 3'd1) begin
                    state_next = ST_IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_HOLD: begin
                // MEM is frozen here, so branch_taken cannot be genuine.
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else if (luh) begin
                    // The release cycle checks a load-use that waited out
                    // the memory stall, so the pipeline never advances into it.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = ST_STALL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (RESET) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            pipe_hold   = 1'b0;
            state_next  = ST_IDLE;
            cnt_next    = 3'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters: load-use stalls, flushes, holds.
    // A bubble without a flush can only come from a load-use stall.
    // ------------------------------------------------------------------
    logic        stat_evt [3];
    logic [31:0] stat_cnt [3];

    assign stat_evt[0] = idex_bubble && !ifid_flush && !RESET;
    assign stat_evt[1] = ifid_flush && !RESET;
    assign stat_evt[2] = pipe_hold;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] count_reg;
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    count_reg <= 32'd0;
                end else if (stat_evt[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
            assign stat_cnt[gi] = count_reg;
        end
    endgenerate

    assign stall_count = stat_cnt[0];
    assign flush_count = stat_cnt[1];
    assign hold_count  = stat_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit -- directed test-plan scenarios followed by random
// stimulus, every cycle compared against a behavioural model kept here.
// Build with HAZARD_STATS_EN defined to also cover the event counters.

module tb_hazard_ctrl_unit;

    localparam int FC = 3;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold}
    localparam logic [5:0] E_RUN   = 6'b110000;
    localparam logic [5:0] E_STALL = 6'b000100;
    localparam logic [5:0] E_HOLD  = 6'b000001;
    localparam logic [5:0] E_FLUSH = 6'b111110;
    localparam logic [5:0] E_RST   = 6'b001110;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic       ifid_uses_rs2, idex_memread, exmem_regwrite, memwb_regwrite;
    logic       branch_taken, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count, hold_count;
`endif

    always #5 CLK = ~CLK;

    hazard_ctrl_unit #(
        .REG_W(5),
        .ZERO_REG(31),
        .FLUSH_CYCLES(FC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2),
        .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2),
        .idex_rd(idex_rd),
        .idex_memread(idex_memread),
        .exmem_rd(exmem_rd),
        .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd),
        .memwb_regwrite(memwb_regwrite),
        .branch_taken(branch_taken),
        .mem_busy(mem_busy),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .exmem_flush(exmem_flush),
        .pipe_hold(pipe_hold),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count),
        .hold_count(hold_count)
`endif
    );

    logic [5:0] ctrl_obs;
    assign ctrl_obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold};

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the pipeline owes some number of flush cycles, may
    // be waiting on memory, or may have just spent a stall cycle.
    // ------------------------------------------------------------------
    int          m_flush_left = 0;
    bit          m_hold  = 1'b0;
    bit          m_stall = 1'b0;
    logic [5:0]  m_exp;
    logic [3:0]  m_fwd;
`ifdef HAZARD_STATS_EN
    int unsigned m_sc = 0, m_fc = 0, m_hc = 0;
`endif

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (exmem_regwrite && exmem_rd != 5'd31 && exmem_rd == src) return 2'b10;
        if (memwb_regwrite && memwb_rd != 5'd31 && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_luh();
        return idex_memread && idex_rd != 5'd31 &&
               (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    endfunction

    always @(negedge CLK) begin
        if (started) begin
`ifdef HAZARD_STATS_EN
            check_eq("stall_count", stall_count, m_sc);
            check_eq("flush_count", flush_count, m_fc);
            check_eq("hold_count", hold_count, m_hc);
`endif
            if (RESET) begin
                m_exp = E_RST;
                m_fwd = 4'b0000;
                m_flush_left = 0;
                m_hold  = 1'b0;
                m_stall = 1'b0;
`ifdef HAZARD_STATS_EN
                m_sc = 0; m_fc = 0; m_hc = 0;
`endif
            end else begin
                m_fwd = {ref_fwd(idex_rs1), ref_fwd(idex_rs2)};
                if (m_flush_left > 0) begin
                    m_exp = E_FLUSH;
                    m_flush_left = branch_taken ? FC - 1 : m_flush_left - 1;
                end else if (m_hold && mem_busy) begin
                    m_exp = E_HOLD;
                end else if (m_hold) begin
                    m_hold = 1'b0;
                    if (ref_luh()) begin
                        m_exp = E_STALL;
                        m_stall = 1'b1;
                    end else begin
                        m_exp = E_RUN;
                    end
                end else if (m_stall) begin
                    m_stall = 1'b0;
                    if (branch_taken) begin
                        m_exp = E_FLUSH;
                        m_flush_left = FC - 1;
                    end else begin
                        m_exp = E_RUN;
                    end
                end else if (branch_taken) begin
                    m_exp = E_FLUSH;
                    m_flush_left = FC - 1;
                end else if (mem_busy) begin
                    m_exp = E_HOLD;
                    m_hold = 1'b1;
                end else if (ref_luh()) begin
                    m_exp = E_STALL;
                    m_stall = 1'b1;
                end else begin
                    m_exp = E_RUN;
                end
`ifdef HAZARD_STATS_EN
                if (m_exp == E_STALL && m_sc != 32'hFFFF_FFFF) m_sc++;
                if (m_exp == E_FLUSH && m_fc != 32'hFFFF_FFFF) m_fc++;
                if (m_exp == E_HOLD  && m_hc != 32'hFFFF_FFFF) m_hc++;
`endif
            end
            check_eq("ctrl", ctrl_obs, m_exp);
            check_eq("fwd", {fwd_a, fwd_b}, m_fwd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_uses_rs2 = 1'b0;
        idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0; idex_memread = 1'b0;
        exmem_rd = 5'd0; exmem_regwrite = 1'b0;
        memwb_rd = 5'd0; memwb_regwrite = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // LDUR X2 in ID/EX, ADD X3,X2,X4 in IF/ID.
    task automatic set_luh();
        idex_memread = 1'b1; idex_rd = 5'd2;
        ifid_rs1 = 5'd2; ifid_rs2 = 5'd4; ifid_uses_rs2 = 1'b1;
    endtask

    function automatic logic [4:0] rnd_reg();
        int unsigned r;
        r = $urandom % 4;
        return (r == 3) ? 5'd31 : 5'(r);
    endfunction

    int n;
    int busy_left = 0;

    initial begin
        clear_inputs();
        RESET = 1'b1;
        tick();
        started = 1'b1;
        @(negedge CLK);
        check_eq("reset_out", ctrl_obs, E_RST);
        tick();
        RESET = 1'b0;
        tick();
        $display("reset: outputs in reset pattern");

        // Load-use: one stall cycle, then no re-stall.
        set_luh();
        @(negedge CLK);
        check_eq("luh_stall", ctrl_obs, E_STALL);
        tick();
        @(negedge CLK);
        check_eq("luh_no_restall", ctrl_obs, E_RUN);
        tick();
        clear_inputs();
        $display("load-use: single stall cycle");

        // Forwarding priority and XZR.
        idex_rs1 = 5'd5;
        exmem_rd = 5'd5; exmem_regwrite = 1'b1;
        memwb_rd = 5'd5; memwb_regwrite = 1'b1;
        @(negedge CLK);
        check_eq("fwd_exmem", fwd_a, 2'b10);
        tick();
        exmem_regwrite = 1'b0;
        @(negedge CLK);
        check_eq("fwd_memwb", fwd_a, 2'b01);
        tick();
        idex_rs1 = 5'd31; exmem_rd = 5'd31; exmem_regwrite = 1'b1; memwb_rd = 5'd31;
        @(negedge CLK);
        check_eq("fwd_xzr", fwd_a, 2'b00);
        tick();
        clear_inputs();
        $display("forwarding: exmem, memwb, xzr");

        // Single branch pulse: FC flush cycles.
        n = 0;
        branch_taken = 1'b1;
        @(negedge CLK); n += int'(ifid_flush);
        tick();
        branch_taken = 1'b0;
        repeat (5) begin
            @(negedge CLK); n += int'(ifid_flush);
            tick();
        end
        check_eq("flush_len", n, FC);
        $display("branch: flush length %0d", n);

        // Second pulse in flush cycle 2 extends to cycle 4.
        n = 0;
        branch_taken = 1'b1;
        @(negedge CLK); n += int'(ifid_flush);
        tick();
        @(negedge CLK); n += int'(ifid_flush);
        tick();
        branch_taken = 1'b0;
        repeat (5) begin
            @(negedge CLK); n += int'(ifid_flush);
            tick();
        end
        check_eq("flush_extend_len", n, 4);
        $display("branch: extended flush length %0d", n);

        // Branch and load-use together: flush wins.
        set_luh();
        branch_taken = 1'b1;
        @(negedge CLK);
        check_eq("br_luh_pc_write", pc_write, 1'b1);
        check_eq("br_luh_flush", ifid_flush, 1'b1);
        tick();
        clear_inputs();
        n = 0;
        repeat (4) begin
            @(negedge CLK); n += int'(!pc_write);
            tick();
        end
        check_eq("br_luh_no_stall", n, 0);
        $display("branch+load-use: flush only");

        // Memory wait of 4 cycles with a pending load-use.
        set_luh();
        mem_busy = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge CLK); n += int'(pipe_hold);
            tick();
        end
        mem_busy = 1'b0;
        @(negedge CLK);
        check_eq("hold_len", n, 4);
        check_eq("busy_then_stall", ctrl_obs, E_STALL);
        tick();
        @(negedge CLK);
        check_eq("busy_after_stall", ctrl_obs, E_RUN);
        tick();
        clear_inputs();
        $display("memory wait: hold %0d cycles then stall", n);

        // Reset during flush cycle 2.
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid_flush", ctrl_obs, E_RST);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("post_rst_idle", ctrl_obs, E_RUN);
`ifdef HAZARD_STATS_EN
        check_eq("stats_cleared", stall_count | flush_count | hold_count, 32'd0);
`endif
        tick();
        $display("reset mid-flush: aborted to idle");

        // Random traffic against the model.
        repeat (3000) begin
            RESET          = ($urandom % 250) == 0;
            branch_taken   = ($urandom % 12) == 0;
            if (busy_left > 0) begin
                mem_busy = 1'b1;
                busy_left--;
            end else if (($urandom % 15) == 0) begin
                mem_busy  = 1'b1;
                busy_left = $urandom_range(0, 4);
            end else begin
                mem_busy = 1'b0;
            end
            ifid_rs1       = rnd_reg();
            ifid_rs2       = rnd_reg();
            ifid_uses_rs2  = 1'($urandom % 2);
            idex_rs1       = rnd_reg();
            idex_rs2       = rnd_reg();
            idex_rd        = rnd_reg();
            idex_memread   = 1'($urandom % 2);
            exmem_rd       = rnd_reg();
            exmem_regwrite = 1'($urandom % 2);
            memwb_rd       = rnd_reg();
            memwb_regwrite = 1'($urandom % 2);
            tick();
        end
        $display("random: 3000 cycles");

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
